tron_mem_responder: RTL and testbench

// - Memory-side responder for the Tron CPU bus: serves instruction fetches, data loads and stores issued by the CPU
//   (address, write data, write enable, fetch-phase flag) against one single-port synchronous block RAM.
// - Also serves a read-only display (VGA) port and owns the memory-mapped LED register.
// - Sits between the Tron CPU top and the RAM; replaces the ad-hoc fetch/data mux plus decoder glue.

---
 rtl/tron_mem_pkg.sv | 21 ++
 rtl/tron_mem_arb.sv | 47 ++++
 rtl/tron_mem_responder.sv | 134 +++++++++++++
 tb/tb_tron_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_mem_pkg.sv
// ---------------------------------------------------------------------------
// tron_mem_pkg
// Shared constants for the Tron memory responder: FSM state encoding and the
// default LED register address and reset instruction.
// No ports (package).
// ---------------------------------------------------------------------------
package tron_mem_pkg;

    typedef logic [2:0] memState_t;

    localparam memState_t IDLE     = 3'd0;
    localparam memState_t CPU_RD   = 3'd1;
    localparam memState_t CPU_DONE = 3'd2;
    localparam memState_t VGA_RD   = 3'd3;
    localparam memState_t VGA_DONE = 3'd4;
    localparam memState_t WR_DONE  = 3'd5;

    localparam logic [15:0] LED_ADDR_DEF  = 16'hFFFF;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

endpackage

// File: rtl/tron_mem_arb.sv
// ---------------------------------------------------------------------------
// tron_mem_arb
// Grant decision for the responder's IDLE state plus the saturating counter
// that stops a busy CPU from starving the display port.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   idle            responder is in IDLE and may grant this cycle
//   cpuReq, vgaReq  pending requests
//   grantCpu        CPU transaction starts this cycle
//   grantVga        VGA read starts this cycle
// ---------------------------------------------------------------------------
module tron_mem_arb
    import tron_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic cpuReq,
    input  logic vgaReq,
    output logic grantCpu,
    output logic grantVga
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starveCnt;
    logic             starved;

    assign starved  = (starveCnt == CNT_W'(STARVE_MAX));
    // VGA wins only when the CPU is absent or has used up its run of grants.
    assign grantVga = idle && vgaReq && (starved || !cpuReq);
    assign grantCpu = idle && cpuReq && !grantVga;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (!vgaReq || grantVga) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            starveCnt <= '0;
        end else if (grantCpu && !starved) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

endmodule

// File: rtl/tron_mem_responder.sv
// ---------------------------------------------------------------------------
// tron_mem_responder
// Memory-side responder for the Tron CPU bus. Serves CPU fetches, loads and
// stores plus a read-only VGA port against one single-port synchronous RAM,
// and owns the memory-mapped LED register.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_req/we/fetch/addr/wdata     CPU request (held until cpu_ready)
//   cpu_ready                       one-cycle completion pulse
//   instruction, mem_data           registered fetch / load results
//   led                             LED register
//   vga_req/addr                    VGA read request (held until vga_valid)
//   vga_valid, vga_rdata            one-cycle pulse with registered read data
//   ram_addr/wdata/we, ram_rdata    RAM interface (read data one cycle late)
// ---------------------------------------------------------------------------
module tron_mem_responder
    import tron_mem_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] LED_ADDR       = ADDR_W'(LED_ADDR_DEF),
    parameter int                VGA_STARVE_MAX = 4,
    parameter logic [DATA_W-1:0] NOP_INSTR      = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_fetch,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] led,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    memState_t         state, nextState;
    logic              idleArb, grantCpu, grantVga;
    logic              cpuIsLed, cpuStore, ramStore, cpuRamRead;
    logic              rdFetch, rdLed;
    logic [ADDR_W-1:0] heldAddr;
    logic [DATA_W-1:0] heldWdata;
    logic [DATA_W-1:0] rdData;

    // Gating with reset keeps ram_we low the instant reset rises, even if a
    // request is sitting on the bus.
    assign idleArb = (state == IDLE) && !reset;

    tron_mem_arb #(
        .STARVE_MAX (VGA_STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .idle     (idleArb),
        .cpuReq   (cpu_req),
        .vgaReq   (vga_req),
        .grantCpu (grantCpu),
        .grantVga (grantVga)
    );

    // A fetch is always a read, whatever cpu_we says.
    assign cpuIsLed   = (cpu_addr == LED_ADDR);
    assign cpuStore   = grantCpu && cpu_we && !cpu_fetch;
    assign ramStore   = cpuStore && !cpuIsLed;
    assign cpuRamRead = grantCpu && !cpuStore && !cpuIsLed;

    assign cpu_ready = (state == WR_DONE) || (state == CPU_DONE);
    assign vga_valid = (state == VGA_DONE);
    assign rdData    = rdLed ? led : ram_rdata;

    // The RAM samples its address at the end of the grant cycle, so the bus
    // is driven combinationally then and held from registers otherwise.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        ram_we    = ramStore;
        ram_addr  = heldAddr;
        ram_wdata = heldWdata;
        if (ramStore || cpuRamRead) ram_addr = cpu_addr;
        if (ramStore)               ram_wdata = cpu_wdata;
        if (grantVga)               ram_addr = vga_addr;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantVga)      nextState = VGA_RD;
                else if (grantCpu) nextState = cpuStore ? WR_DONE : CPU_RD;
            end
            CPU_RD:  nextState = CPU_DONE;
            VGA_RD:  nextState = VGA_DONE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instruction <= NOP_INSTR;
            mem_data    <= '0;
            led         <= '0;
            vga_rdata   <= '0;
            heldAddr    <= '0;
            heldWdata   <= '0;
            rdFetch     <= 1'b0;
            rdLed       <= 1'b0;
        end else begin
            state <= nextState;
            if (ramStore || cpuRamRead || grantVga) heldAddr <= ram_addr;
            if (ramStore) heldWdata <= cpu_wdata;
            if (cpuStore && cpuIsLed) led <= cpu_wdata;
            if (grantCpu) begin
                rdFetch <= cpu_fetch;
                rdLed   <= cpuIsLed;
            end
            // Only the targeted result register moves; the other one holds.
            if (state == CPU_RD) begin
                if (rdFetch) instruction <= rdData;
                else         mem_data    <= rdData;
            end
            if (state == VGA_RD) vga_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_tron_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_tron_mem_responder
// Directed bench for tron_mem_responder with a behavioural RAM on the RAM
// port and an independent shadow of the intended memory contents.
// ---------------------------------------------------------------------------
module tb_tron_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_fetch;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_ready;
    logic [15:0] instruction, mem_data, led;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_valid;
    logic [15:0] vga_rdata;
    logic [15:0] ram_addr, ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] ram   [int];
    logic [15:0] model [int];

    always #5 clk = ~clk;

    tron_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_fetch   (cpu_fetch),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .instruction (instruction),
        .mem_data    (mem_data),
        .led         (led),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_valid   (vga_valid),
        .vga_rdata   (vga_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    function automatic logic [15:0] initPat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] modelRd(input logic [15:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : initPat(a);
    endfunction

    // Behavioural single-port synchronous RAM, read-before-write.
    always @(posedge clk) begin
        logic [15:0] rd;
        rd = ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : initPat(ram_addr);
        if (ram_we) ram[int'(ram_addr)] = ram_wdata;
        ram_rdata <= rd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction: raise request, wait for its pulse, drop the
    // request, then watch one idle cycle for stray pulses.
    task automatic runOp(input bit vga, input bit we, input bit fetch,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output int pulses, output int weCycles);
        lat = -1; pulses = 0; weCycles = 0;
        @(posedge clk); #1;
        if (vga) begin
            vga_req = 1'b1; vga_addr = addr;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_fetch = fetch;
            cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (ram_we) weCycles++;
            if (vga ? vga_valid : cpu_ready) begin
                lat = k; pulses++;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; vga_req = 1'b0;
        @(negedge clk);
        if (ram_we) weCycles++;
        if (cpu_ready || vga_valid) pulses++;
    endtask

    int lat, pulses, weCycles;
    int nCpu, cpuAt, vgaAt;
    bit seenV, seenReady, dropCpu, dropVga;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_fetch = 1'b0;
        cpu_addr = 16'h0010; cpu_wdata = 16'hDEAD;
        vga_req = 1'b0; vga_addr = 16'h0000;

        // Reset state, with a store sitting on the bus.
        repeat (3) @(negedge clk);
        check("rst_instruction", 32'(instruction), 32'h0000);
        check("rst_mem_data",    32'(mem_data),    32'h0000);
        check("rst_led",         32'(led),         32'h0000);
        check("rst_vga_rdata",   32'(vga_rdata),   32'h0000);
        check("rst_ram_addr",    32'(ram_addr),    32'h0000);
        check("rst_ram_we",      32'(ram_we),      32'h0);
        check("rst_cpu_ready",   32'(cpu_ready),   32'h0);
        check("rst_vga_valid",   32'(vga_valid),   32'h0);
        @(posedge clk); #1;
        cpu_req = 1'b0; reset = 1'b0;

        // Store then fetch back.
        runOp(0, 1, 0, 16'h0040, 16'h1234, lat, pulses, weCycles);
        model[16'h0040] = 16'h1234;
        check("st_latency",  32'(lat),      32'd1);
        check("st_we_cycles", 32'(weCycles), 32'd1);
        check("st_pulses",   32'(pulses),   32'd1);
        runOp(0, 0, 1, 16'h0040, 16'h0000, lat, pulses, weCycles);
        check("fetch_latency",  32'(lat),         32'd2);
        check("fetch_instr",    32'(instruction), 32'h1234);
        check("fetch_mem_data", 32'(mem_data),    32'h0000);

        // LED register store and load.
        runOp(0, 1, 0, 16'hFFFF, 16'hA5A5, lat, pulses, weCycles);
        check("led_st_latency", 32'(lat),      32'd1);
        check("led_value",      32'(led),      32'hA5A5);
        check("led_no_ram_we",  32'(weCycles), 32'd0);
        runOp(0, 0, 0, 16'hFFFF, 16'h0000, lat, pulses, weCycles);
        check("led_ld_latency", 32'(lat),         32'd2);
        check("led_ld_data",    32'(mem_data),    32'hA5A5);
        check("led_ld_instr",   32'(instruction), 32'h1234);

        // Fetch with cpu_we high is still a read.
        runOp(0, 1, 1, 16'h0007, 16'hBEEF, lat, pulses, weCycles);
        check("fetch_we_instr", 32'(instruction), 32'(modelRd(16'h0007)));
        check("fetch_we_no_we", 32'(weCycles),    32'd0);

        // Starvation: continuous CPU loads with VGA pending.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_fetch = 1'b0; cpu_addr = 16'h0041;
        vga_req = 1'b1; vga_addr = 16'h0050;
        nCpu = 0; seenV = 1'b0;
        for (int k = 0; k < 60 && !seenV; k++) begin
            @(negedge clk);
            if (vga_valid) seenV = 1'b1;
            else if (cpu_ready) nCpu++;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; vga_req = 1'b0;
        check("starve_vga_seen",   32'(seenV),     32'd1);
        check("starve_cpu_grants", 32'(nCpu),      32'd4);
        check("starve_vga_data",   32'(vga_rdata), 32'(modelRd(16'h0050)));
        check("starve_mem_data",   32'(mem_data),  32'(modelRd(16'h0041)));

        // Simultaneous requests with an empty starve count.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_fetch = 1'b0; cpu_addr = 16'h0060;
        vga_req = 1'b1; vga_addr = 16'h0040;
        cpuAt = -1; vgaAt = -1;
        for (int k = 0; k < 30 && vgaAt < 0; k++) begin
            @(negedge clk);
            dropCpu = cpu_ready; dropVga = vga_valid;
            if (cpu_ready && cpuAt < 0) cpuAt = k;
            if (vga_valid) vgaAt = k;
            @(posedge clk); #1;
            if (dropCpu) cpu_req = 1'b0;
            if (dropVga) vga_req = 1'b0;
        end
        cpu_req = 1'b0; vga_req = 1'b0;
        check("simul_cpu_at",   32'(cpuAt),     32'd2);
        check("simul_vga_at",   32'(vgaAt),     32'd5);
        check("simul_mem_data", 32'(mem_data),  32'(modelRd(16'h0060)));
        check("simul_vga_data", 32'(vga_rdata), 32'h1234);

        // Reset in the middle of a fetch.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_fetch = 1'b1; cpu_addr = 16'h0040;
        @(posedge clk); #2;
        reset = 1'b1;
        seenReady = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready || ram_we) seenReady = 1'b1;
        end
        check("rstmid_no_ready", 32'(seenReady),   32'd0);
        check("rstmid_instr",    32'(instruction), 32'h0000);
        check("rstmid_led",      32'(led),         32'h0000);
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0;
        runOp(0, 0, 1, 16'h0040, 16'h0000, lat, pulses, weCycles);
        check("rstmid_fetch_lat",   32'(lat),         32'd2);
        check("rstmid_fetch_instr", 32'(instruction), 32'h1234);

        // Random single-requester traffic against the shadow model.
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [15:0] a, d;
            op = $urandom_range(0, 3);
            a  = 16'($urandom_range(0, 31));
            d  = 16'($urandom);
            case (op)
                0: begin
                    runOp(0, 1, 0, a, d, lat, pulses, weCycles);
                    model[int'(a)] = d;
                    check("rnd_st_lat", 32'(lat),      32'd1);
                    check("rnd_st_we",  32'(weCycles), 32'd1);
                end
                1: begin
                    runOp(0, 0, 0, a, 16'h0000, lat, pulses, weCycles);
                    check("rnd_ld_lat",  32'(lat),      32'd2);
                    check("rnd_ld_data", 32'(mem_data), 32'(modelRd(a)));
                end
                2: begin
                    runOp(0, 0, 1, a, 16'h0000, lat, pulses, weCycles);
                    check("rnd_fe_lat",  32'(lat),         32'd2);
                    check("rnd_fe_data", 32'(instruction), 32'(modelRd(a)));
                end
                default: begin
                    runOp(1, 0, 0, a, 16'h0000, lat, pulses, weCycles);
                    check("rnd_vga_lat",  32'(lat),       32'd2);
                    check("rnd_vga_data", 32'(vga_rdata), 32'(modelRd(a)));
                end
            endcase
            check("rnd_pulses", 32'(pulses), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
